// File: rtl/layering_pipeline_rx.sv
// layering_pipeline_rx: array-side receiver for the layering pipeline control word.
// Decodes the per-group load/swap strobes, tracks the ping-pong weight bank of each
// PE group, flags protocol violations in sticky error bits and counts finished
// layer sequences. Every output comes straight from a flop.
module layering_pipeline_rx #(
   parameter int NG    = 4,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3*NG-1:0]   valid_ctrl,
   input  logic              busy,
   input  logic              err_clr,
   output logic [NG-1:0]     load_en,
   output logic [NG-1:0]     swap_pulse,
   output logic [NG-1:0]     bank_sel,
   output logic [NG-1:0]     pending,
   output logic              seq_done,
   output logic [CNT_W-1:0]  layers_done,
   output logic [3:0]        err
);

   logic [NG-1:0] load_d;
   logic [NG-1:0] swap_d;
   logic [NG-1:0] bank_d;
   logic [NG-1:0] pending_d;
   logic [3:0]    err_new;
   logic [3:0]    err_d;
   logic          busy_q;
   logic          seq_end;

   // Per-group decode of the sampled word; malformed group fields (load and swap
   // together, or the reserved bit set) are ignored apart from the framing flag.
   // Error detection always looks at the pending state as it stood before this edge.
   always_comb begin
      load_d    = '0;
      swap_d    = '0;
      bank_d    = bank_sel;
      pending_d = pending;
      err_new   = '0;
      seq_end   = busy_q & ~busy;
      for (int g = 0; g < NG; g++) begin
         if (valid_ctrl[3*g+2] || (valid_ctrl[3*g] && valid_ctrl[3*g+1])) begin
            err_new[2] = 1'b1;
         end else if (valid_ctrl[3*g]) begin
            load_d[g]    = 1'b1;
            pending_d[g] = 1'b1;
            if (pending[g]) begin
               err_new[1] = 1'b1;
            end
         end else if (valid_ctrl[3*g+1]) begin
            swap_d[g] = 1'b1;
            if (pending[g]) begin
               bank_d[g]    = ~bank_sel[g];
               pending_d[g] = 1'b0;
            end else begin
               err_new[0] = 1'b1;
            end
         end
      end
      if (!busy && (valid_ctrl != '0)) begin
         err_new[2] = 1'b1;
      end
      if (seq_end && (pending != '0)) begin
         err_new[3] = 1'b1;
      end
      err_d = err_clr ? err_new : (err | err_new);
   end

   // Register all decoded results, the busy history and the sequence counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_en     <= '0;
         swap_pulse  <= '0;
         bank_sel    <= '0;
         pending     <= '0;
         seq_done    <= 1'b0;
         layers_done <= '0;
         err         <= '0;
         busy_q      <= 1'b0;
      end else begin
         load_en    <= load_d;
         swap_pulse <= swap_d;
         bank_sel   <= bank_d;
         pending    <= pending_d;
         seq_done   <= seq_end;
         err        <= err_d;
         busy_q     <= busy;
         if (seq_end) begin
            layers_done <= layers_done + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_layering_pipeline_rx.sv
// Testbench for layering_pipeline_rx: a table of one-cycle vectors with
// hand-computed expected outputs, then hand-written wrap and async-reset sequences.
module tb_layering_pipeline_rx;

   localparam int NG    = 4;
   localparam int CNT_W = 2;

   logic              clk;
   logic              rst_n;
   logic [3*NG-1:0]   valid_ctrl;
   logic              busy;
   logic              err_clr;
   logic [NG-1:0]     load_en;
   logic [NG-1:0]     swap_pulse;
   logic [NG-1:0]     bank_sel;
   logic [NG-1:0]     pending;
   logic              seq_done;
   logic [CNT_W-1:0]  layers_done;
   logic [3:0]        err;

   int total;
   int bad;

   typedef struct {
      logic        busy;
      logic [11:0] ctrl;
      logic        clr;
      logic [3:0]  load;
      logic [3:0]  swap;
      logic [3:0]  bank;
      logic [3:0]  pend;
      logic [3:0]  err;
      logic        done;
      logic [1:0]  layers;
   } vec_t;

   vec_t vecs[$];

   layering_pipeline_rx #(.NG(NG), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_ctrl  (valid_ctrl),
      .busy        (busy),
      .err_clr     (err_clr),
      .load_en     (load_en),
      .swap_pulse  (swap_pulse),
      .bank_sel    (bank_sel),
      .pending     (pending),
      .seq_done    (seq_done),
      .layers_done (layers_done),
      .err         (err)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void addRow(input logic b, input logic [11:0] c, input logic cl,
                                  input logic [3:0] ld, input logic [3:0] sw,
                                  input logic [3:0] bk, input logic [3:0] pd,
                                  input logic [3:0] er, input logic dn,
                                  input logic [1:0] ly);
      vec_t v;
      v.busy = b; v.ctrl = c; v.clr = cl; v.load = ld; v.swap = sw;
      v.bank = bk; v.pend = pd; v.err = er; v.done = dn; v.layers = ly;
      vecs.push_back(v);
   endfunction

   // Drive one word, let one rising edge sample it, settle just after the edge.
   task automatic applyStimulus(input logic b, input logic [11:0] c, input logic cl);
      busy       = b;
      valid_ctrl = c;
      err_clr    = cl;
      @(posedge clk);
      #1;
      busy       = b;
      valid_ctrl = '0;
      err_clr    = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkRow(input string tag, input vec_t v);
      checkOutput({tag, " load_en"},     int'(load_en),     int'(v.load));
      checkOutput({tag, " swap_pulse"},  int'(swap_pulse),  int'(v.swap));
      checkOutput({tag, " bank_sel"},    int'(bank_sel),    int'(v.bank));
      checkOutput({tag, " pending"},     int'(pending),     int'(v.pend));
      checkOutput({tag, " err"},         int'(err),         int'(v.err));
      checkOutput({tag, " seq_done"},    int'(seq_done),    int'(v.done));
      checkOutput({tag, " layers_done"}, int'(layers_done), int'(v.layers));
   endtask

   initial begin
      vec_t zero;
      total      = 0;
      bad        = 0;
      busy       = 1'b0;
      valid_ctrl = '0;
      err_clr    = 1'b0;
      rst_n      = 1'b0;

      //      busy ctrl    clr load     swap     bank     pend     err      done ly
      // nominal sequence
      addRow(1, 12'h240, 0, 4'b1100, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 0, 0);
      addRow(1, 12'h000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 0, 0);
      addRow(1, 12'h480, 0, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 4'b0000, 0, 0);
      addRow(1, 12'h000, 0, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 0, 0);
      addRow(1, 12'h240, 0, 4'b1100, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 0, 0);
      addRow(1, 12'h000, 0, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 0, 0);
      addRow(1, 12'h480, 0, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 0, 0);
      addRow(1, 12'h000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
      addRow(0, 12'h000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1);
      addRow(0, 12'h000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1);
      // swap without load, then clear
      addRow(1, 12'h080, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 0, 1);
      addRow(1, 12'h000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1);
      // double load
      addRow(1, 12'h040, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 1);
      addRow(1, 12'h040, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 0, 1);
      addRow(1, 12'h000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 1);
      // framing: load+swap together, reserved bit
      addRow(1, 12'h0C0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 0, 1);
      addRow(1, 12'h000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 1);
      addRow(1, 12'h100, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 0, 1);
      addRow(1, 12'h000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 1);
      // legal swap, clean end of sequence, then a word outside busy
      addRow(1, 12'h080, 0, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 1);
      addRow(0, 12'h000, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1, 2);
      addRow(0, 12'h040, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 0, 2);
      addRow(0, 12'h000, 1, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 0, 2);
      // incomplete sequence, then clear colliding with a new double load
      addRow(1, 12'h080, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 2);
      addRow(1, 12'h040, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 2);
      addRow(0, 12'h000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 1, 3);
      addRow(1, 12'h040, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 0, 3);
      addRow(1, 12'h000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 3);
      // end with pending still set: counter wraps 3 -> 0, incomplete flag again
      addRow(0, 12'h000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 1, 0);

      // reset state
      #2;
      zero = '{busy:0, ctrl:0, clr:0, load:0, swap:0, bank:0, pend:0, err:0, done:0, layers:0};
      checkRow("reset", zero);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].busy, vecs[i].ctrl, vecs[i].clr);
         checkRow($sformatf("row%0d", i), vecs[i]);
         @(negedge clk);
      end

      // wrap: four complete sequences from reset, counter reads 1, 2, 3, 0
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 12'h240, 1'b0);
         applyStimulus(1'b1, 12'h480, 1'b0);
         applyStimulus(1'b0, 12'h000, 1'b0);
         checkOutput($sformatf("wrap%0d seq_done", k), int'(seq_done), 1);
         checkOutput($sformatf("wrap%0d layers_done", k), int'(layers_done), (k + 1) % 4);
         checkOutput($sformatf("wrap%0d err", k), int'(err), 0);
         checkOutput($sformatf("wrap%0d bank_sel", k), int'(bank_sel), (k % 2 == 0) ? 12 : 0);
         @(negedge clk);
      end

      // async reset mid-sequence, between clock edges
      applyStimulus(1'b1, 12'h240, 1'b0);
      checkOutput("prereset load_en", int'(load_en), 12);
      checkOutput("prereset pending", int'(pending), 12);
      #2;
      rst_n = 1'b0;
      #1;
      checkRow("async_reset", zero);
      busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // busy_q was cleared by reset, so busy low here must not look like an end of sequence
      applyStimulus(1'b0, 12'h000, 1'b0);
      checkOutput("post_reset seq_done", int'(seq_done), 0);
      checkOutput("post_reset layers_done", int'(layers_done), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
